plru_state_unit: RTL and testbench

//  Per-set tree pseudo-LRU tracker for the 4-way set-associative cache. Holds one 3-bit PLRU word per set.

---
 rtl/plru_state_unit_pkg.sv | 39 +++
 rtl/plru_state_unit_if.sv | 30 +++
 rtl/plru_state_unit_victim_decode.sv | 12 +
 rtl/plru_state_unit.sv | 89 ++++++++
 tb/tb_plru_state_unit.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/plru_state_unit_pkg.sv
// Shared definitions for the per-set tree pseudo-LRU tracker:
// word/way widths, FSM states and the PLRU update rule.
package plru_state_unit_pkg;

   localparam int PLRU_W   = 3;
   localparam int WAY_BITS = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } plruFsm_e;

   // Touched tree bits are pointed away from the accessed way; untouched bits are kept.
   function automatic logic [PLRU_W-1:0] plru_update(input logic [PLRU_W-1:0]   state,
                                                     input logic [WAY_BITS-1:0] way);
      logic [PLRU_W-1:0] newState;
      newState = state;
      case (way)
         2'd0: begin
            newState[0] = 1'b1;
            newState[1] = 1'b1;
         end
         2'd1: begin
            newState[0] = 1'b1;
            newState[1] = 1'b0;
         end
         2'd2: begin
            newState[0] = 1'b0;
            newState[2] = 1'b1;
         end
         default: begin
            newState[0] = 1'b0;
            newState[2] = 1'b0;
         end
      endcase
      return newState;
   endfunction

endpackage

// File: rtl/plru_state_unit_if.sv
// Request/response bundle between the cache controller and the PLRU tracker.
interface plru_state_unit_if
   import plru_state_unit_pkg::*;
#(
   parameter int SET_BITS = 3
);

   logic                flushReq;
   logic                ready;
   logic                lookupValid;
   logic [SET_BITS-1:0] lookupSet;
   logic                updateValid;
   logic [SET_BITS-1:0] updateSet;
   logic [WAY_BITS-1:0] updateWay;
   logic                victimValid;
   logic [WAY_BITS-1:0] victimWay;
   logic [PLRU_W-1:0]   lookupState;
   logic [PLRU_W-1:0]   nextState;

   modport master (
      output flushReq, lookupValid, lookupSet, updateValid, updateSet, updateWay,
      input  ready, victimValid, victimWay, lookupState, nextState
   );

   modport slave (
      input  flushReq, lookupValid, lookupSet, updateValid, updateSet, updateWay,
      output ready, victimValid, victimWay, lookupState, nextState
   );

endinterface

// File: rtl/plru_state_unit_victim_decode.sv
// Combinational decode of a 3-bit PLRU tree word into its victim way.
module plru_victim_decode
   import plru_state_unit_pkg::*;
(
   input  logic [PLRU_W-1:0]   plruWord,
   output logic [WAY_BITS-1:0] victimWay
);

   // The root bit chooses the half; the matching leaf bit chooses the way inside it.
   assign victimWay = plruWord[0] ? {1'b1, plruWord[2]} : {1'b0, plruWord[1]};

endmodule

// File: rtl/plru_state_unit.sv
// Per-set tree pseudo-LRU tracker for a 4-way cache: victim lookup with
// same-cycle update forwarding, per-access updates and a one-set-per-cycle flush.
module plru_state_unit
   import plru_state_unit_pkg::*;
#(
   parameter int NUM_SETS = 8,
   parameter int SET_BITS = 3
)(
   input logic               clk,
   input logic               reset,
   plru_state_unit_if.slave  bus
);

   localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(NUM_SETS - 1);

   logic [PLRU_W-1:0]   plruMem [NUM_SETS];
   plruFsm_e            fsmState;
   logic [SET_BITS-1:0] flushCnt;

   logic [PLRU_W-1:0]   storedWord;
   logic [PLRU_W-1:0]   fwdWord;
   logic [PLRU_W-1:0]   projWord;
   logic [WAY_BITS-1:0] fwdVictim;

   // A lookup racing an update to the same set must observe the post-update word.
   always_comb begin
      storedWord = plruMem[bus.lookupSet];
      fwdWord    = storedWord;
      if (bus.updateValid && (bus.updateSet == bus.lookupSet)) begin
         fwdWord = plru_update(storedWord, bus.updateWay);
      end
   end

   plru_victim_decode victimDecode (
      .plruWord  (fwdWord),
      .victimWay (fwdVictim)
   );

   assign projWord = plru_update(fwdWord, fwdVictim);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_SETS; i++) begin
            plruMem[i] <= '0;
         end
         fsmState        <= IDLE;
         flushCnt        <= '0;
         bus.ready       <= 1'b1;
         bus.victimValid <= 1'b0;
         bus.victimWay   <= '0;
         bus.lookupState <= '0;
         bus.nextState   <= '0;
      end else begin
         bus.victimValid <= 1'b0;
         case (fsmState)
            IDLE: begin
               if (bus.updateValid) begin
                  plruMem[bus.updateSet] <= plru_update(plruMem[bus.updateSet], bus.updateWay);
               end
               if (bus.lookupValid) begin
                  bus.victimValid <= 1'b1;
                  bus.victimWay   <= fwdVictim;
                  bus.lookupState <= fwdWord;
                  bus.nextState   <= projWord;
               end
               if (bus.flushReq) begin
                  fsmState  <= FLUSH;
                  bus.ready <= 1'b0;
               end
            end
            // Requests are dropped while flushing; the FSM owns the array here.
            FLUSH: begin
               plruMem[flushCnt] <= '0;
               if (flushCnt == LAST_SET) begin
                  flushCnt  <= '0;
                  fsmState  <= IDLE;
                  bus.ready <= 1'b1;
               end else begin
                  flushCnt <= flushCnt + 1'b1;
               end
            end
            default: begin
               fsmState <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_plru_state_unit.sv
// Self-checking bench for plru_state_unit: directed vector table, flush/reset
// sequences and randomized traffic against a last-touched tree model.
module tb_plru_state_unit;

   localparam int NUM_SETS = 8;
   localparam int SET_BITS = 3;

   logic clk;
   logic reset;

   plru_state_unit_if #(.SET_BITS(SET_BITS)) bus();

   plru_state_unit #(
      .NUM_SETS (NUM_SETS),
      .SET_BITS (SET_BITS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string      name;
      int         fl, lv, ls, uv, us, uw;
      logic       eValid;
      logic [1:0] eWay;
      logic [2:0] eLook;
      logic [2:0] eNext;
   } vec_t;

   vec_t vecs[$];
   int   nVec = 0;
   int   nBad = 0;

   // Model: each set remembers which half was touched last and which way was
   // touched last inside each half; the victim lies on the untouched side.
   int mHalf  [NUM_SETS];
   int mLast0 [NUM_SETS];
   int mLast1 [NUM_SETS];
   int flushLeft;

   logic       eReady;
   logic       eValid;
   logic [1:0] eWay;
   logic [2:0] eLook;
   logic [2:0] eNext;

   function automatic logic [2:0] encodeWord(int lh, int l0, int l1);
      logic [2:0] r;
      r[0] = (lh == 0);
      r[1] = (l0 == 0);
      r[2] = (l1 == 2);
      return r;
   endfunction

   function automatic int victimFrom(int lh, int l0, int l1);
      if (lh == 0) return (l1 == 2) ? 3 : 2;
      return (l0 == 0) ? 1 : 0;
   endfunction

   function automatic void touch(int s, int w);
      mHalf[s] = w / 2;
      if (w < 2) mLast0[s] = w;
      else       mLast1[s] = w;
   endfunction

   function automatic void clearSet(int s);
      mHalf[s]  = 1;
      mLast0[s] = 1;
      mLast1[s] = 3;
   endfunction

   function automatic void modelReset();
      for (int s = 0; s < NUM_SETS; s++) clearSet(s);
      flushLeft = 0;
      eReady    = 1'b1;
      eValid    = 1'b0;
      eWay      = '0;
      eLook     = '0;
      eNext     = '0;
   endfunction

   function automatic void modelEdge(int fl, int lv, int ls, int uv, int us, int uw);
      int v, lh, l0, l1;
      if (eReady) begin
         if (uv != 0) touch(us, uw);
         eValid = (lv != 0);
         if (lv != 0) begin
            v     = victimFrom(mHalf[ls], mLast0[ls], mLast1[ls]);
            eWay  = 2'(v);
            eLook = encodeWord(mHalf[ls], mLast0[ls], mLast1[ls]);
            lh    = v / 2;
            l0    = mLast0[ls];
            l1    = mLast1[ls];
            if (v < 2) l0 = v;
            else       l1 = v;
            eNext = encodeWord(lh, l0, l1);
         end
         if (fl != 0) begin
            eReady    = 1'b0;
            flushLeft = NUM_SETS;
         end
      end else begin
         eValid = 1'b0;
         clearSet(NUM_SETS - flushLeft);
         flushLeft--;
         if (flushLeft == 0) eReady = 1'b1;
      end
   endfunction

   function automatic void addVec(string n, int fl, int lv, int ls, int uv, int us, int uw,
                                  int ev, int ew, logic [2:0] el, logic [2:0] en);
      vec_t v;
      v.name   = n;
      v.fl     = fl;
      v.lv     = lv;
      v.ls     = ls;
      v.uv     = uv;
      v.us     = us;
      v.uw     = uw;
      v.eValid = (ev != 0);
      v.eWay   = 2'(ew);
      v.eLook  = el;
      v.eNext  = en;
      vecs.push_back(v);
   endfunction

   task automatic driveInputs(int fl, int lv, int ls, int uv, int us, int uw);
      bus.flushReq    = (fl != 0);
      bus.lookupValid = (lv != 0);
      bus.lookupSet   = 3'(ls);
      bus.updateValid = (uv != 0);
      bus.updateSet   = 3'(us);
      bus.updateWay   = 2'(uw);
   endtask

   task automatic applyStimulus(int fl, int lv, int ls, int uv, int us, int uw);
      driveInputs(fl, lv, ls, uv, us, uw);
      @(posedge clk);
      #1;
      modelEdge(fl, lv, ls, uv, us, uw);
   endtask

   task automatic checkOutput(string name);
      nVec++;
      if (bus.ready !== eReady || bus.victimValid !== eValid || bus.victimWay !== eWay ||
          bus.lookupState !== eLook || bus.nextState !== eNext) begin
         nBad++;
         $display("[TB] FAIL %s: got ready=%b valid=%b way=%0d state=%b next=%b, exp ready=%b valid=%b way=%0d state=%b next=%b",
                  name, bus.ready, bus.victimValid, bus.victimWay, bus.lookupState, bus.nextState,
                  eReady, eValid, eWay, eLook, eNext);
      end
   endtask

   task automatic checkVec(vec_t v);
      nVec++;
      if (bus.ready !== 1'b1 || bus.victimValid !== v.eValid ||
          (v.eValid && (bus.victimWay !== v.eWay || bus.lookupState !== v.eLook ||
                        bus.nextState !== v.eNext))) begin
         nBad++;
         $display("[TB] FAIL %s: got ready=%b valid=%b way=%0d state=%b next=%b, exp ready=1 valid=%b way=%0d state=%b next=%b",
                  v.name, bus.ready, bus.victimValid, bus.victimWay, bus.lookupState, bus.nextState,
                  v.eValid, v.eWay, v.eLook, v.eNext);
      end
   endtask

   task automatic loadAllSets();
      for (int s = 0; s < NUM_SETS; s++) begin
         applyStimulus(0, 0, 0, 1, s, $urandom_range(0, 3));
         applyStimulus(0, 0, 0, 1, s, (s % 2 == 0) ? 0 : 2);
      end
   endtask

   initial begin
      int lowCount;
      int fl, lv, ls, uv, us, uw;

      driveInputs(0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_held");
      reset = 1'b0;
      #1;
      checkOutput("reset_released");

      addVec("lookup_set0",        0, 1, 0, 0, 0, 0, 1, 0, 3'b000, 3'b011);
      addVec("upd_s2_w0",          0, 0, 0, 1, 2, 0, 0, 0, 3'b000, 3'b000);
      addVec("upd_s2_w2",          0, 0, 0, 1, 2, 2, 0, 0, 3'b000, 3'b000);
      addVec("lookup_set2",        0, 1, 2, 0, 0, 0, 1, 1, 3'b110, 3'b101);
      addVec("fwd_s3_w0",          0, 1, 3, 1, 3, 0, 1, 2, 3'b011, 3'b110);
      addVec("upd_s5_w0",          0, 0, 0, 1, 5, 0, 0, 0, 3'b000, 3'b000);
      addVec("upd_s5_w1",          0, 0, 0, 1, 5, 1, 0, 0, 3'b000, 3'b000);
      addVec("upd_s5_w2",          0, 0, 0, 1, 5, 2, 0, 0, 3'b000, 3'b000);
      addVec("upd_s5_w3",          0, 0, 0, 1, 5, 3, 0, 0, 3'b000, 3'b000);
      addVec("lookup_set5",        0, 1, 5, 0, 0, 0, 1, 0, 3'b000, 3'b011);
      addVec("lookup_s3_upd_s4",   0, 1, 3, 1, 4, 3, 1, 2, 3'b011, 3'b110);
      addVec("lookup_set4",        0, 1, 4, 0, 0, 0, 1, 0, 3'b000, 3'b011);
      addVec("fwd_s6_w1",          0, 1, 6, 1, 6, 1, 1, 2, 3'b001, 3'b100);
      addVec("idle_after_lookup",  0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].fl, vecs[i].lv, vecs[i].ls, vecs[i].uv, vecs[i].us, vecs[i].uw);
         checkVec(vecs[i]);
      end

      // Flush with busy traffic: the pulse cycle still services its lookup.
      loadAllSets();
      for (int s = 0; s < NUM_SETS; s++) begin
         applyStimulus(0, 1, s, 0, 0, 0);
         checkOutput("preflush_lookup");
      end
      applyStimulus(1, 1, 1, 1, 1, 3);
      checkOutput("flush_pulse");
      lowCount = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.ready !== 1'b0) break;
         lowCount++;
         applyStimulus($urandom_range(0, 1), 1, $urandom_range(0, 7), 1, $urandom_range(0, 7),
                       $urandom_range(0, 3));
         checkOutput("during_flush");
      end
      nVec++;
      if (lowCount != NUM_SETS) begin
         nBad++;
         $display("[TB] FAIL flush_length: got %0d ready-low cycles, exp %0d", lowCount, NUM_SETS);
      end
      for (int s = 0; s < NUM_SETS; s++) begin
         applyStimulus(0, 1, s, 0, 0, 0);
         checkOutput("postflush_lookup");
      end

      // Reset arriving in the third flush cycle aborts the flush outright.
      loadAllSets();
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      #2;
      reset = 1'b1;
      #1;
      modelReset();
      checkOutput("reset_midflush");
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
         applyStimulus(0, 1, s, 0, 0, 0);
         checkOutput("post_reset_lookup");
      end

      for (int i = 0; i < 400; i++) begin
         fl = ($urandom_range(0, 39) == 0) ? 1 : 0;
         lv = $urandom_range(0, 1);
         ls = $urandom_range(0, NUM_SETS - 1);
         uv = $urandom_range(0, 1);
         us = ($urandom_range(0, 3) == 0) ? ls : $urandom_range(0, NUM_SETS - 1);
         uw = $urandom_range(0, 3);
         applyStimulus(fl, lv, ls, uv, us, uw);
         checkOutput("random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
      $finish;
   end

endmodule
